rm_swap_ctrl: RTL

//  Sequences partial reconfiguration of one reconfigurable partition (RP), e.g. the shift or

---
 rtl/rm_swap_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rm_swap_ctrl.sv
// rm_swap_ctrl: sequences a partial-reconfiguration swap for a single
// reconfigurable partition. Accepts a request for an RM id. The sequence is:
// decouple the RP, drain, pulse the PR loader, wait for it to finish,
// hold the new RM in reset, release it, let it settle, and recouple.
//
// Ports
//   pl_clk, pl_resetn      clock, asynchronous active-low reset
//   req_valid/req_ready    swap request handshake, req_id = RM to load
//   pr_start, pr_id        loader trigger pulse and RM id for the loader
//   pr_done, pr_error      loader completion / failure pulses
//   decouple, rm_resetn    RP isolation and active-low RM reset
//   rm_data, led_out       raw RP output and registered, decoupled LED drive
//   busy, swap_done        swap in progress / one-cycle success pulse
//   active_id              RM currently loaded and running
//   err, err_code          sticky fault flag; 01 loader error, 10 timeout
//
// state   | meaning
// IDLE    | RM running and coupled, waiting for a request
// DRAIN   | RP decoupled, letting in-flight activity drain
// PROG    | RM in reset, loader triggered, waiting for done/error/timeout
// HOLD    | new RM loaded, reset still held
// RELEASE | reset released, still decoupled while the RM settles
// FAULT   | load failed; RP stays isolated until a new request arrives

module rm_swap_ctrl #(
    parameter int          RM_ID_W     = 2,
    parameter int          INIT_ID     = 0,
    parameter int unsigned DRAIN_CYC   = 16,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 2**24,
    parameter int          HOLD_LAST   = 1,
    parameter logic [3:0]  SAFE_VAL    = 4'b0000
) (
    input  logic               pl_clk,
    input  logic               pl_resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [RM_ID_W-1:0] req_id,
    output logic               pr_start,
    output logic [RM_ID_W-1:0] pr_id,
    input  logic               pr_done,
    input  logic               pr_error,
    output logic               decouple,
    output logic               rm_resetn,
    input  logic [3:0]         rm_data,
    output logic [3:0]         led_out,
    output logic               busy,
    output logic               swap_done,
    output logic [RM_ID_W-1:0] active_id,
    output logic               err,
    output logic [1:0]         err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_PROG, S_HOLD, S_RELEASE, S_FAULT
    } state_t;

    // Down-counter reload values; each phase ends when the count hits zero,
    // so a reload of N-1 gives exactly N cycles in that phase.
    localparam logic [31:0] DRAIN_LD  = 32'(DRAIN_CYC - 1);
    localparam logic [31:0] HOLD_LD   = 32'(RST_HOLD - 1);
    localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] TO_LD     = 32'(TIMEOUT_CYC - 1);
    localparam logic [RM_ID_W-1:0] INIT_VAL = RM_ID_W'(INIT_ID);

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               decouple_q, decouple_d;
    logic               rm_resetn_q, rm_resetn_d;
    logic               pr_start_q, pr_start_d;
    logic [RM_ID_W-1:0] pr_id_q, pr_id_d;
    logic [RM_ID_W-1:0] active_id_q, active_id_d;
    logic               busy_q, busy_d;
    logic               swap_done_q, swap_done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [3:0]         led_q, led_d;
    logic               hs;

    assign req_ready = (state_q == S_IDLE) || (state_q == S_FAULT);
    assign hs        = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != 32'd0) ? cnt_q - 32'd1 : 32'd0;
        decouple_d  = decouple_q;
        rm_resetn_d = rm_resetn_q;
        pr_start_d  = 1'b0;
        pr_id_d     = pr_id_q;
        active_id_d = active_id_q;
        busy_d      = busy_q;
        swap_done_d = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE, S_FAULT: begin
                // Out of reset the RM comes up on the first edge in IDLE;
                // in FAULT it stays held until a new request.
                if (state_q == S_IDLE) rm_resetn_d = 1'b1;
                if (hs) begin
                    state_d     = S_DRAIN;
                    cnt_d       = DRAIN_LD;
                    pr_id_d     = req_id;
                    err_d       = 1'b0;
                    err_code_d  = 2'b00;
                    decouple_d  = 1'b1;
                    busy_d      = 1'b1;
                    rm_resetn_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 32'd0) begin
                    state_d     = S_PROG;
                    cnt_d       = TO_LD;
                    pr_start_d  = 1'b1;
                    rm_resetn_d = 1'b0;
                end
            end
            S_PROG: begin
                if (pr_error) begin
                    state_d    = S_FAULT;
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    busy_d     = 1'b0;
                end else if (pr_done) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else if (cnt_q == 32'd0) begin
                    state_d    = S_FAULT;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    busy_d     = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == 32'd0) begin
                    state_d     = S_RELEASE;
                    cnt_d       = SETTLE_LD;
                    rm_resetn_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == 32'd0) begin
                    state_d     = S_IDLE;
                    decouple_d  = 1'b0;
                    busy_d      = 1'b0;
                    swap_done_d = 1'b1;
                    active_id_d = pr_id_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // LED path uses the decouple value already registered for this cycle.
    always_comb begin
        if (!decouple_q)        led_d = rm_data;
        else if (HOLD_LAST != 0) led_d = led_q;
        else                    led_d = SAFE_VAL;
    end

    always_ff @(posedge pl_clk or negedge pl_resetn) begin
        if (!pl_resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            decouple_q  <= 1'b0;
            rm_resetn_q <= 1'b0;
            pr_start_q  <= 1'b0;
            pr_id_q     <= INIT_VAL;
            active_id_q <= INIT_VAL;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            led_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            decouple_q  <= decouple_d;
            rm_resetn_q <= rm_resetn_d;
            pr_start_q  <= pr_start_d;
            pr_id_q     <= pr_id_d;
            active_id_q <= active_id_d;
            busy_q      <= busy_d;
            swap_done_q <= swap_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            led_q       <= led_d;
        end
    end

    assign decouple  = decouple_q;
    assign rm_resetn = rm_resetn_q;
    assign pr_start  = pr_start_q;
    assign pr_id     = pr_id_q;
    assign active_id = active_id_q;
    assign busy      = busy_q;
    assign swap_done = swap_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign led_out   = led_q;

endmodule
